// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN gate datapath.
//   - Q-format constant helpers (parameterised by the fractional bit count)
//   - activation type codes
//   - activation-stage FSM state encoding
// No ports: package only.
package rnn_pkg;

    localparam int unsigned ActSigmoid = 0;
    localparam int unsigned ActTanh    = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } act_state_e;

    // Constants are exact in Q format for qm >= 5.
    function automatic int q_one(input int qm);
        return 1 << qm;
    endfunction

    function automatic int q_half(input int qm);
        return 1 << (qm - 1);
    endfunction

    function automatic int q_0p625(input int qm);
        return 5 << (qm - 3);
    endfunction

    function automatic int q_0p84375(input int qm);
        return 27 << (qm - 5);
    endfunction

    function automatic int q_th_1p0(input int qm);
        return 1 << qm;
    endfunction

    function automatic int q_th_2p375(input int qm);
        return 19 << (qm - 3);
    endfunction

    function automatic int q_th_5p0(input int qm);
        return 5 << qm;
    endfunction

endpackage

// File: rtl/pwl_sigmoid.sv
// Combinational shift-only piecewise-linear sigmoid core.
//   s2 : signed pre-activation, QN.QM with sign (BITWIDTH bits)
//   y  : sigmoid(s2) approximation in [0, 1.0], same format
module pwl_sigmoid
    import rnn_pkg::*;
#(
    parameter  int unsigned QN       = 6,
    parameter  int unsigned QM       = 11,
    localparam int unsigned BITWIDTH = QN + QM + 1
) (
    input  logic [BITWIDTH-1:0] s2,
    output logic [BITWIDTH-1:0] y
);

    localparam int unsigned AW = BITWIDTH + 1;

    localparam logic [AW-1:0]       TH_1P0   = AW'(q_th_1p0(QM));
    localparam logic [AW-1:0]       TH_2P375 = AW'(q_th_2p375(QM));
    localparam logic [AW-1:0]       TH_5P0   = AW'(q_th_5p0(QM));
    localparam logic [BITWIDTH-1:0] ONE      = BITWIDTH'(q_one(QM));
    localparam logic [BITWIDTH-1:0] HALF     = BITWIDTH'(q_half(QM));
    localparam logic [BITWIDTH-1:0] C0P625   = BITWIDTH'(q_0p625(QM));
    localparam logic [BITWIDTH-1:0] C0P84375 = BITWIDTH'(q_0p84375(QM));

    logic [AW-1:0]       s2_ext;
    logic [AW-1:0]       a;
    logic [BITWIDTH-1:0] y_pos;

    always_comb begin
        s2_ext = {s2[BITWIDTH-1], s2};
        // One extra bit so |most negative| does not overflow.
        a      = s2[BITWIDTH-1] ? (~s2_ext + AW'(1)) : s2_ext;

        if (a >= TH_5P0) begin
            y_pos = ONE;
        end else if (a >= TH_2P375) begin
            y_pos = BITWIDTH'(a >> 5) + C0P84375;
        end else if (a >= TH_1P0) begin
            y_pos = BITWIDTH'(a >> 3) + C0P625;
        end else begin
            y_pos = BITWIDTH'(a >> 2) + HALF;
        end

        // Sigmoid symmetry: sig(-a) = 1 - sig(a).
        y = s2[BITWIDTH-1] ? (ONE - y_pos) : y_pos;
    end

endmodule

// File: rtl/act_stage.sv
// Element-wise activation stage behind the dot-product engine.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   dataReadyIn  : engine ready flag; its rising edge starts a pass
//   inputVector  : NROW signed results, element i at [i*BITWIDTH +: BITWIDTH]
//   biasVector   : NROW signed per-row biases, same packing
//   outputVector : activated vector, same packing, held between passes
//   actReady     : one-cycle pulse when outputVector is complete
//   busy         : high from capture through the actReady cycle
//   overrun      : sticky, a capture request arrived while busy
module act_stage
    import rnn_pkg::*;
#(
    parameter  int unsigned NROW           = 16,
    parameter  int unsigned QN             = 6,
    parameter  int unsigned QM             = 11,
    parameter  int unsigned ACT_TYPE       = ActSigmoid,
    localparam int unsigned BITWIDTH       = QN + QM + 1,
    localparam int unsigned LAYER_BITWIDTH = BITWIDTH * NROW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dataReadyIn,
    input  logic [LAYER_BITWIDTH-1:0] inputVector,
    input  logic [LAYER_BITWIDTH-1:0] biasVector,
    output logic [LAYER_BITWIDTH-1:0] outputVector,
    output logic                      actReady,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned IW = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int unsigned SW = BITWIDTH + 1;

    localparam logic [IW-1:0]       LAST_IDX = IW'(NROW - 1);
    localparam logic [BITWIDTH-1:0] SAT_MAX  = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic [BITWIDTH-1:0] SAT_MIN  = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [BITWIDTH-1:0] ONE      = BITWIDTH'(q_one(QM));

    act_state_e state_q, state_d;

    logic                      drdy_q;
    logic                      overrun_q;
    logic [IW-1:0]             idx_q;
    logic                      drain_q;
    logic [LAYER_BITWIDTH-1:0] x_buf_q, b_buf_q;
    logic [BITWIDTH-1:0]       s1_q;
    logic [IW-1:0]             s1_idx_q;
    logic                      s1_valid_q;
    logic [LAYER_BITWIDTH-1:0] out_q;

    logic                rise, capture;
    logic [BITWIDTH-1:0] x_el, b_el, s_sat, s2;
    logic [SW-1:0]       sum;
    logic [BITWIDTH-1:0] y_pwl, act_val;

    assign rise    = dataReadyIn & ~drdy_q;
    assign capture = rise & (state_q == StIdle);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (capture) state_d = StRun;
            StRun:   if (idx_q == LAST_IDX) state_d = StDrain;
            // Two cycles lets the last element clear both pipeline stages.
            StDrain: if (drain_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy     = (state_q != StIdle);
        actReady = (state_q == StDone);
    end

    // Control and capture buffers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drdy_q    <= 1'b0;
            overrun_q <= 1'b0;
            idx_q     <= '0;
            drain_q   <= 1'b0;
            x_buf_q   <= '0;
            b_buf_q   <= '0;
        end else begin
            drdy_q    <= dataReadyIn;
            overrun_q <= overrun_q | (rise & (state_q != StIdle));
            drain_q   <= (state_q == StDrain) & ~drain_q;
            if (capture) begin
                idx_q   <= '0;
                x_buf_q <= inputVector;
                b_buf_q <= biasVector;
            end else if ((state_q == StRun) && (idx_q != LAST_IDX)) begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    // Stage 1: saturating bias add, optional doubling for tanh
    always_comb begin
        x_el  = x_buf_q[32'(idx_q)*BITWIDTH +: BITWIDTH];
        b_el  = b_buf_q[32'(idx_q)*BITWIDTH +: BITWIDTH];
        sum   = {x_el[BITWIDTH-1], x_el} + {b_el[BITWIDTH-1], b_el};
        s_sat = (sum[SW-1] != sum[SW-2]) ? (sum[SW-1] ? SAT_MIN : SAT_MAX)
                                         : sum[BITWIDTH-1:0];
        if (ACT_TYPE == ActTanh) begin
            // tanh(x) = 2*sig(2x) - 1
            s2 = (s_sat[BITWIDTH-1] != s_sat[BITWIDTH-2])
               ? (s_sat[BITWIDTH-1] ? SAT_MIN : SAT_MAX)
               : {s_sat[BITWIDTH-2:0], 1'b0};
        end else begin
            s2 = s_sat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            s1_idx_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= (state_q == StRun);
            if (state_q == StRun) begin
                s1_q     <= s2;
                s1_idx_q <= idx_q;
            end
        end
    end

    // Stage 2: PWL core and output slot write
    pwl_sigmoid #(
        .QN (QN),
        .QM (QM)
    ) u_pwl (
        .s2 (s1_q),
        .y  (y_pwl)
    );

    always_comb begin
        if (ACT_TYPE == ActTanh) begin
            // y <= 1.0, so the doubled value fits without the top bit.
            act_val = {y_pwl[BITWIDTH-2:0], 1'b0} - ONE;
        end else begin
            act_val = y_pwl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else if (s1_valid_q) begin
            out_q[32'(s1_idx_q)*BITWIDTH +: BITWIDTH] <= act_val;
        end
    end

    assign outputVector = out_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/act_stage.md
# act_stage

Element-wise activation stage sitting directly downstream of the dot-product engine in each RNN gate. On the engine's ready flag it captures the NROW-wide fixed-point result vector, adds a per-row bias with saturation, and applies a shift-only piecewise-linear sigmoid or tanh. It streams one element per cycle through a 2-stage pipeline and presents the full activated vector with a one-cycle completion pulse. Its output feeds the gate element-wise (cell/hidden update) logic.

## Interface
- NROW, 16: elements per vector
- QN, 6: integer bits (Q format, sign excluded)
- QM, 11: fractional bits
- ACT_TYPE, 0: 0 = sigmoid, 1 = tanh
- BITWIDTH (derived) = QN+QM+1; LAYER_BITWIDTH (derived) = BITWIDTH*NROW
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- dataReadyIn  in  1  dot-product ready flag (may stay high several cycles)
- inputVector  in  LAYER_BITWIDTH  signed dot-product results, element i at [i*BITWIDTH +: BITWIDTH]
- biasVector  in  LAYER_BITWIDTH  signed per-row bias, same packing, static during a pass
- outputVector  out  LAYER_BITWIDTH  activated vector, same packing
- actReady  out  1  one-cycle pulse: outputVector complete
- busy  out  1  high from capture until actReady cycle inclusive
- overrun  out  1  sticky: capture request arrived while busy

## Operation
- Capture on rising edge of dataReadyIn (dataReadyIn=1, registered previous=0); a level held high triggers exactly one pass.
- Capture latches inputVector and biasVector into internal buffers; inputs may change afterwards.
- FSM: IDLE -> RUN (capture) -> DRAIN (after element NROW-1 issued) -> DONE (2 cycles later) -> IDLE; DONE asserts actReady.
- RUN: index counter 0..NROW-1, one element issued per cycle; no wrap beyond NROW-1.
- Stage 1 (registered): s = sat_BITWIDTH(x + b), computed at BITWIDTH+1 bits, clamped to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]. For tanh, s2 = sat(2*s) else s2 = s.
- Stage 2 (registered into outputVector slot): a = |s2| (BITWIDTH+1 bits, no overflow at min); one = 1<<QM.
  - a >= 5.0: y = one
  - 2.375 <= a < 5.0: y = (a>>5) + 0.84375
  - 1.0 <= a < 2.375: y = (a>>3) + 0.625
  - a < 1.0: y = (a>>2) + 0.5
  - s2 < 0: y = one - y. Shifts are floor (logical on non-negative a). Constants = round(c*2^QM).
  - tanh: out = 2*y - one; sigmoid: out = y.
- Edge detected while busy: ignored, overrun set; stays set until reset.
- outputVector holds last result until the next pass overwrites elements in index order.

## Timing
- Reset (async, any state): state IDLE, counter 0, outputVector 0, actReady 0, busy 0, overrun 0, edge-detect register 0. Reset mid-pass aborts; no actReady follows.
- Capture edge = T0; element k enters stage 1 at T(k+1), written to outputVector at T(k+2).
- Last element written at T(NROW+1); actReady high during cycle after T(NROW+2), i.e. NROW+3 edges after capture (19 at defaults).
- busy rises at T0, falls with the edge ending the actReady cycle.
- Edge detected in the same cycle actReady is high: counts as overrun (ignored).
- New capture accepted from the cycle after actReady.

## Structure
- Shared package/header (rnn_pkg): Q-format constants (ONE, HALF, 0.625, 0.84375, thresholds 1.0/2.375/5.0 in QM), saturation limits, FSM state encoding, ACT_TYPE codes.
- Sub-module pwl_sigmoid: combinational BITWIDTH-in/BITWIDTH-out PWL core (stage-2 logic), reusable by the cell-update block for tanh(c).

## Test plan
- Sigmoid, x=0, b=0 all rows -> all outputs 1024; actReady exactly 19 cycles after capture edge, single pulse.
- Sigmoid, x=2048, b=0 -> 1536; x=-2048 -> 512; x=20000 -> 2048; x=-20000 -> 0; x=3000, b=2000 -> (5000>>5)+1728=1884.
- Saturation: x=131071, b=131071 -> stage-1 sum 131071, output 2048; x=-131072, b=-1 -> 0.
- Tanh, x=1024 -> 1024; x=0 -> 0; x=-1024 -> -1024; x=20000 -> 2048.
- dataReadyIn held high 2 cycles -> exactly one pass; second rising edge at T5 -> ignored, overrun=1, results unchanged.
- Async reset asserted at T8 of a pass -> outputs/flags 0 immediately, no actReady; fresh capture after release completes normally.
